regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/regfile.sv | 176 +++++++++++++++++
 tb/tb_regfile.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// regfile -- 32 x 32-bit general-purpose register file, two read ports, one
// write port.
//
// Register 0 is hard-wired to zero and is never written. Reads are purely
// combinational. A write is visible in the same cycle through a bypass from
// the write port, and from the array starting on the next cycle.
//
// Optional feature (macro REGFILE_CLEAR_EN):
//   When defined, a post-reset clear sequencer is compiled in. After rst is
//   released it writes RESET_FILL into registers 1..31, one register per cycle,
//   so the clear takes 31 cycles. busy is high for that whole time. While busy
//   is high, the write port is ignored and both read ports return zero.
//   When the macro is not defined, busy is tied low, reset leaves the array
//   alone, and the array contents at power-up are undefined.
//
// Parameter:
//   RESET_FILL  value written to registers 1..31 by the clear sequence
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   we/waddr/wdata  write port (from the write-back stage)
//   re1/raddr1      read port 1 enable and address
//   rdata1          read port 1 data (combinational)
//   re2/raddr2      read port 2 enable and address
//   rdata2          read port 2 data (combinational)
//   busy            clear sequence in progress

// One read port. Outputs are forced to zero in a fixed priority order; after
// that, a same-cycle write to the same address wins over the stored value.
module regfile_rd (
  input  logic        rst_i,
  input  logic        busy_i,
  input  logic        re_i,
  input  logic [4:0]  raddr_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_i,
  output logic [31:0] rdata_o
);

  always_comb begin
    rdata_o = '0;
    if (rst_i || busy_i || raddr_i == 5'd0 || !re_i)
      rdata_o = '0;
    else if (we_i && waddr_i == raddr_i)
      // The bypass does not check busy_i: when busy_i is high the branch
      // above has already returned zero.
      rdata_o = wdata_i;
    else
      rdata_o = mem_i;
  end

endmodule

module regfile #(
  parameter logic [31:0] RESET_FILL = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        re1,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic        re2,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  output logic        busy
);

  localparam int NUM_RD = 2;

  // Storage. Entry 0 exists but is never written and never read.
  logic [31:0] mem_q [32];

  // Request from the clear sequencer. It takes priority over the external
  // write port.
  logic        clr_we;
  logic [4:0]  clr_ptr;

`ifdef REGFILE_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_e;

  state_e     state_q, state_d;
  logic [4:0] ptr_q, ptr_d;

  // A reset always restarts the clear from register 1, even when a clear is
  // already in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= 5'd1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    unique case (state_q)
      IDLE: ;
      CLEAR: begin
        clr_we = 1'b1;
        ptr_d  = ptr_q + 5'd1;
        if (ptr_q == 5'd31)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign clr_ptr = ptr_q;
  assign busy    = (state_q == CLEAR);
`else
  assign clr_we  = 1'b0;
  assign clr_ptr = 5'd0;
  assign busy    = 1'b0;
`endif

  // Single physical write port, shared by the clear sequencer and the
  // external write path.
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = waddr;
    wr_data = wdata;
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_addr = clr_ptr;
      wr_data = RESET_FILL;
    end else if (we && !busy && waddr != 5'd0) begin
      wr_en = 1'b1;
    end
  end

  // rst blocks every write, so reset never changes the array contents.
  always_ff @(posedge clk) begin
    if (!rst && wr_en)
      mem_q[wr_addr] <= wr_data;
  end

  // Read ports. Packing them into arrays lets one generate loop build both.
  logic [NUM_RD-1:0]       re_a;
  logic [NUM_RD-1:0][4:0]  raddr_a;
  logic [NUM_RD-1:0][31:0] rdata_a;

  assign re_a    = {re2, re1};
  assign raddr_a = {raddr2, raddr1};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rd u_rd (
      .rst_i   (rst),
      .busy_i  (busy),
      .re_i    (re_a[p]),
      .raddr_i (raddr_a[p]),
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .mem_i   (mem_q[raddr_a[p]]),
      .rdata_o (rdata_a[p])
    );
  end

  assign rdata1 = rdata_a[0];
  assign rdata2 = rdata_a[1];

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

  localparam logic [31:0] FILL = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile #(.RESET_FILL(FILL)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge. Outputs are sampled
  // away from that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts the cycles until busy drops. The wait is bounded so the run
  // always finishes.
  task automatic wait_clear(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b1; raddr1 = 5'd4; re2 = 1'b1; raddr2 = 5'd6;

    tick();
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_rdata2", rdata2, 32'h0);
`ifdef REGFILE_CLEAR_EN
    chk("rst_busy", {31'b0, busy}, 32'h1);
`else
    chk("rst_busy", {31'b0, busy}, 32'h0);
`endif
    rst = 1'b0;

`ifdef REGFILE_CLEAR_EN
    // The clear lasts 31 cycles. A write that arrives in the middle of it
    // must be dropped, and reads must return zero while it runs.
    chk("clr_busy_start", {31'b0, busy}, 32'h1);
    for (int k = 1; k <= 30; k++) begin
      if (k == 15) begin
        we = 1'b1; waddr = 5'd2; wdata = 32'h0BADF00D; re1 = 1'b1; raddr1 = 5'd2;
        chk("clr_rd_bypass_blocked", rdata1, 32'h0);
      end
      tick();
      we = 1'b0;
      chk($sformatf("clr_busy_%0d", k), {31'b0, busy}, 32'h1);
    end
    tick();
    chk("clr_busy_done", {31'b0, busy}, 32'h0);
    for (int r = 0; r < 32; r++) begin
      raddr1 = 5'(r); raddr2 = 5'(31 - r);
      #1;
      chk($sformatf("clr_rd1_r%0d", r), rdata1, (r == 0) ? 32'h0 : FILL);
      chk($sformatf("clr_rd2_r%0d", 31 - r), rdata2, (r == 31) ? 32'h0 : FILL);
    end

    // A reset in the middle of a clear restarts the full 31-cycle sequence.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    rst = 1'b1; tick();
    chk("midrst_busy", {31'b0, busy}, 32'h1);
    rst = 1'b0;
    wait_clear(cnt);
    chk("midrst_len", 32'(cnt), 32'd31);
`endif

    // Write, then read through the array on the next cycle.
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b0; raddr2 = 5'd5;
    #1;
    chk("wr5_rd1", rdata1, 32'hDEADBEEF);
    chk("re2_off", rdata2, 32'h0);
    re2 = 1'b1; #1;
    chk("wr5_rd2", rdata2, 32'hDEADBEEF);

    // Same-cycle bypass to both ports, then the value read from the array.
    we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
    raddr1 = 5'd7; raddr2 = 5'd7; #1;
    chk("byp7_rd1", rdata1, 32'h12345678);
    chk("byp7_rd2", rdata2, 32'h12345678);
    tick();
    we = 1'b0; #1;
    chk("arr7_rd1", rdata1, 32'h12345678);

    // A write to register 0 neither bypasses nor sticks.
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0; #1;
    chk("r0_same", rdata1, 32'h0);
    tick();
    we = 1'b0; #1;
    chk("r0_next", rdata1, 32'h0);

    // Boundary register 31: bypass on port 2, array read on port 1.
    we = 1'b1; waddr = 5'd31; wdata = 32'hCAFEF00D; raddr2 = 5'd31; raddr1 = 5'd5; #1;
    chk("byp31_rd2", rdata2, 32'hCAFEF00D);
    chk("indep_rd1", rdata1, 32'hDEADBEEF);
    tick();
    we = 1'b0; raddr1 = 5'd31; #1;
    chk("arr31_rd1", rdata1, 32'hCAFEF00D);

    // A disabled port does not bypass.
    we = 1'b1; waddr = 5'd9; wdata = 32'h99999999; re1 = 1'b0; raddr1 = 5'd9; #1;
    chk("byp_re_off", rdata1, 32'h0);
    tick();
    we = 1'b0; re1 = 1'b1; #1;
    chk("arr9_rd1", rdata1, 32'h99999999);

    // Reset blocks writes and zeroes reads. Without the clear feature the
    // array keeps its contents across the reset.
    we = 1'b1; waddr = 5'd3; wdata = 32'h11111111;
    tick();
    rst = 1'b1; wdata = 32'h22222222; raddr1 = 5'd3; raddr2 = 5'd3; #1;
    chk("rst_rd1_zero", rdata1, 32'h0);
    chk("rst_rd2_zero", rdata2, 32'h0);
    tick();
    rst = 1'b0; we = 1'b0;
`ifdef REGFILE_CLEAR_EN
    wait_clear(cnt);
    chk("post_rst_len", 32'(cnt), 32'd31);
    #1;
    chk("post_rst_r3", rdata1, FILL);
`else
    #1;
    chk("post_rst_r3", rdata1, 32'h11111111);
    raddr2 = 5'd5; #1;
    chk("post_rst_r5", rdata2, 32'hDEADBEEF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
